fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline; produces the IF/ID bundle consumed by decode: PC, PC+4, instruction word, predicted-taken flag.
- Drives a single-outstanding-request instruction memory port.
- Handles hazard-unit stalls (keep) and EX/MEM and decode-early redirects.
- Optionally predicts B-type/JAL targets in fetch using a 2-bit BHT.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BHT_ENTRIES, 64, BHT depth (power of 2); index = pc[log2(BHT_ENTRIES)+1:2].
- NOP_INST, 32'h0000_0013, bubble word (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- keep  in  1  hazard stall; IF/ID outputs hold.
- redirect_valid  in  1  EX/MEM redirect (mispredict, jalr, trap, mret).
- redirect_pc  in  32  redirect target.
- early_branch_valid  in  1  decode early-branch redirect.
- early_branch_pc  in  32  early-branch target.
- bht_update_valid  in  1  resolved conditional branch.
- bht_update_pc  in  32  PC of the resolved branch.
- bht_update_taken  in  1  resolved direction.
- imem_req  out  1  request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_ready  in  1  response valid this cycle.
- imem_rdata  in  32  instruction word; valid with imem_ready.
- PC_pype0  out  32  PC of the instruction in IF/ID.
- PCp4_pype0  out  32  PC_pype0+4.
- Instraction_pype  out  32  instruction word, or NOP_INST.
- is_branch_predict_pype0  out  1  fetch redirected on a predicted-taken instruction.

Behaviour:
- Reset (async):
  - PC_pype0=0, PCp4_pype0=0, Instraction_pype=NOP_INST, is_branch_predict_pype0=0.
  - pc=RESET_PC, skid buffer empty, state=IDLE.
  - BHT counters = 2'b01 (weakly not-taken).
- States:
  - IDLE: one cycle, imem_req=0, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc; address held stable until imem_ready.
  - HOLD: word captured during keep sits in the skid buffer; imem_req=0.
  - DROP: a redirect arrived with a request in flight; imem_req=1 at the stale address; the response is discarded on imem_ready; then FETCH at the new pc.
- FETCH, imem_ready, keep=0:
  - IF/ID <= {pc, pc+4, imem_rdata, pred}.
  - pc <= pred ? pred_target : pc+4.
  - Latency: the word appears on the outputs the cycle after imem_ready.
- FETCH, imem_ready, keep=1:
  - Word, pc, pred and target go to the skid buffer; state -> HOLD.
  - IF/ID outputs hold.
- HOLD, keep falls:
  - Buffer moves to IF/ID; pc advances as above; state -> FETCH.
- FETCH, no imem_ready, keep=1: request stays asserted; outputs hold.
- Redirect priority: redirect_valid > early_branch_valid > prediction > sequential.
- Any redirect (overrides keep):
  - pc <= target; IF/ID <= bubble (PC 0, NOP_INST, pred 0); skid buffer cleared.
  - Request outstanding and imem_ready=0 -> DROP.
  - Otherwise -> FETCH next cycle at the target; a same-cycle imem_ready word is discarded.
- Redirect while in DROP: update pc, remain in DROP.
- Addresses: pc[1:0] forced 0; pc+4 wraps modulo 2^32.
- Any rst assertion mid-transaction: state returns to IDLE; the in-flight response is ignored; the memory must tolerate request abandonment.

Optional Feature:
- Macro: BRANCH_PREDICT_EN.
- Defined:
  - Word pre-decoded on capture.
  - opcode 1100011: pred = BHT[idx][1]; target = pc + sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - opcode 1101111 (JAL): pred=1; target = pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - JALR is never predicted.
  - bht_update_valid: saturating +1 on taken, -1 on not-taken, at index of bht_update_pc.
  - Same-cycle lookup and update on the same index: lookup sees the old value.
- Undefined: pred=0 always; sequential fetch only; BHT logic and bht_update_* inputs ignored.

Decomposition:
- Shared define file gets OP_BRA, OP_JAL, OP_JALR, NOP_INST, and fetch state encodings (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2, DROP=2'd3).
- One sub-module: branch_predictor_bht, holding the counter array, lookup, update and target adders; instantiated only under BRANCH_PREDICT_EN.

Test Plan:
- Reset, then imem_ready every cycle with words 0x00000093, 0x00100113 -> PC_pype0 0x0 then 0x4; first word visible 1 cycle after ready; PCp4 0x4/0x8.
- keep=1 for 3 cycles when ready arrives at pc 0x8 -> outputs hold the 0x4 entry; keep falls -> 0x8 word emitted; no fetch lost or duplicated.
- redirect_valid with redirect_pc=0x100 while request at 0x10 is outstanding (ready 2 cycles later) -> bubble emitted, stale response dropped, next imem_addr=0x100.
- redirect_valid and early_branch_valid in the same cycle (0x200 vs 0x300) -> pc=0x200.
- BRANCH_PREDICT_EN: JAL +16 at 0x20 -> next imem_addr 0x30, pred=1; beq at 0x40 after two taken updates -> predicted taken to 0x40+imm.
- Without BRANCH_PREDICT_EN: same JAL -> next address 0x24, pred=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared opcodes, bubble word, fetch FSM encoding and IF/ID payload types for fetch_stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_BRA  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    // IF/ID bundle handed to decode
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcp4;
        logic [XLEN-1:0] inst;
        logic            pred;
    } ifid_t;

    // word captured while decode is stalled
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            pred;
        logic [XLEN-1:0] target;
    } skid_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_branch_predictor_bht.sv
// 2-bit BHT plus B-type/JAL target pre-decode for fetch_stage.
// Compiled only when BRANCH_PREDICT_EN is defined.
`ifdef BRANCH_PREDICT_EN
module branch_predictor_bht #(
    parameter int unsigned ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    output logic        o_pred_c,
    output logic [31:0] o_target_c,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken
);
    import fetch_stage_pkg::*;

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic [1:0]       r_bht [ENTRIES];
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic [31:0]      w_imm_b;
    logic [31:0]      w_imm_j;
    logic             w_unused;

    assign w_rd_idx = i_pc[IDX_W+1:2];
    assign w_wr_idx = i_upd_pc[IDX_W+1:2];
    assign w_unused = ^{i_upd_pc[31:IDX_W+2], i_upd_pc[1:0]};

    assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    // lookup reads the pre-update counter value
    always_comb begin
        o_pred_c   = 1'b0;
        o_target_c = i_pc + 32'd4;
        case (i_inst[6:0])
            OP_BRA: begin
                o_pred_c   = r_bht[w_rd_idx][1];
                o_target_c = i_pc + w_imm_b;
            end
            OP_JAL: begin
                o_pred_c   = 1'b1;
                o_target_c = i_pc + w_imm_j;
            end
            OP_JALR: o_pred_c = 1'b0;
            default: o_pred_c = 1'b0;
        endcase
    end

    // saturating counter training from resolved branches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_bht[IDX_W'(i)] <= 2'b01;
            end
        end else if (i_upd_valid) begin
            if (i_upd_taken && (r_bht[w_wr_idx] != 2'b11)) begin
                r_bht[w_wr_idx] <= r_bht[w_wr_idx] + 2'd1;
            end else if (!i_upd_taken && (r_bht[w_wr_idx] != 2'b00)) begin
                r_bht[w_wr_idx] <= r_bht[w_wr_idx] - 2'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/fetch_stage.sv
// IF stage: single-outstanding imem port, skid buffer for stalls, redirects, IF/ID register.
// Define BRANCH_PREDICT_EN to enable BHT/JAL prediction in fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        early_branch_valid,
    input  logic [31:0] early_branch_pc,
    input  logic        bht_update_valid,
    input  logic [31:0] bht_update_pc,
    input  logic        bht_update_taken,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_pype0,
    output logic [31:0] PCp4_pype0,
    output logic [31:0] Instraction_pype,
    output logic        is_branch_predict_pype0
);
    import fetch_stage_pkg::fetch_state_e;
    import fetch_stage_pkg::ifid_t;
    import fetch_stage_pkg::skid_t;
    import fetch_stage_pkg::align_pc;
    import fetch_stage_pkg::IDLE;
    import fetch_stage_pkg::FETCH;
    import fetch_stage_pkg::HOLD;
    import fetch_stage_pkg::DROP;

    localparam ifid_t BUBBLE     = {32'h0, 32'h0, NOP_INST, 1'b0};
    localparam skid_t SKID_EMPTY = {32'h0, NOP_INST, 1'b0, 32'h0};

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_addr;
    logic         r_req;
    ifid_t        r_ifid;
    skid_t        r_skid;

    logic         w_pred;
    logic [31:0]  w_target;
    logic         w_redir;
    logic [31:0]  w_redir_pc;
    logic [31:0]  w_cap_next;
    logic [31:0]  w_skid_next;
    logic         w_outstanding;

`ifdef BRANCH_PREDICT_EN
    branch_predictor_bht #(
        .ENTRIES     (BHT_ENTRIES)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .i_pc        (r_addr),
        .i_inst      (imem_rdata),
        .o_pred_c    (w_pred),
        .o_target_c  (w_target),
        .i_upd_valid (bht_update_valid),
        .i_upd_pc    (bht_update_pc),
        .i_upd_taken (bht_update_taken)
    );
`else
    logic w_unused_bht;

    assign w_pred       = 1'b0;
    assign w_target     = r_addr + 32'd4;
    assign w_unused_bht = ^{bht_update_valid, bht_update_pc, bht_update_taken, 32'(BHT_ENTRIES),
                            fetch_stage_pkg::OP_BRA, fetch_stage_pkg::OP_JAL, fetch_stage_pkg::OP_JALR};
`endif

    // EX/MEM redirect outranks the decode early-branch redirect
    assign w_redir       = redirect_valid | early_branch_valid;
    assign w_redir_pc    = align_pc(redirect_valid ? redirect_pc : early_branch_pc);
    assign w_cap_next    = align_pc(w_pred ? w_target : r_pc + 32'd4);
    assign w_skid_next   = align_pc(r_skid.pred ? r_skid.target : r_skid.pc + 32'd4);
    assign w_outstanding = ((r_state == FETCH) || (r_state == DROP)) && !imem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_pc    <= align_pc(RESET_PC);
            r_addr  <= align_pc(RESET_PC);
            r_req   <= 1'b0;
            r_ifid  <= BUBBLE;
            r_skid  <= SKID_EMPTY;
        end else if (w_redir) begin
            // flush; a request still in flight must be drained before refetching
            r_pc   <= w_redir_pc;
            r_ifid <= BUBBLE;
            r_skid <= SKID_EMPTY;
            r_req  <= 1'b1;
            if (w_outstanding) begin
                r_state <= DROP;
            end else begin
                r_state <= FETCH;
                r_addr  <= w_redir_pc;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                    if (!keep) r_ifid <= BUBBLE;
                end
                FETCH: begin
                    if (imem_ready) begin
                        if (keep) begin
                            r_skid  <= {r_pc, imem_rdata, w_pred, w_target};
                            r_state <= HOLD;
                            r_req   <= 1'b0;
                        end else begin
                            r_ifid <= {r_pc, r_pc + 32'd4, imem_rdata, w_pred};
                            r_pc   <= w_cap_next;
                            r_addr <= w_cap_next;
                        end
                    end else if (!keep) begin
                        r_ifid <= BUBBLE;
                    end
                end
                HOLD: begin
                    if (!keep) begin
                        r_ifid  <= {r_skid.pc, r_skid.pc + 32'd4, r_skid.inst, r_skid.pred};
                        r_pc    <= w_skid_next;
                        r_addr  <= w_skid_next;
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                DROP: begin
                    // stale response is consumed and discarded here
                    if (imem_ready) begin
                        r_state <= FETCH;
                        r_addr  <= r_pc;
                    end
                    if (!keep) r_ifid <= BUBBLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_req                = r_req;
    assign imem_addr               = r_addr;
    assign PC_pype0                = r_ifid.pc;
    assign PCp4_pype0              = r_ifid.pcp4;
    assign Instraction_pype        = r_ifid.inst;
    assign is_branch_predict_pype0 = r_ifid.pred;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirects, prediction, mid-transaction reset.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef BRANCH_PREDICT_EN
    localparam logic [31:0] EXP_JAL_NEXT = 32'h30;
    localparam logic [31:0] EXP_JAL_PRED = 32'h1;
    localparam logic [31:0] EXP_BEQ_NEXT = 32'h60;
    localparam logic [31:0] EXP_BEQ_PRED = 32'h1;
`else
    localparam logic [31:0] EXP_JAL_NEXT = 32'h24;
    localparam logic [31:0] EXP_JAL_PRED = 32'h0;
    localparam logic [31:0] EXP_BEQ_NEXT = 32'h44;
    localparam logic [31:0] EXP_BEQ_PRED = 32'h0;
`endif

    logic        clk;
    logic        rst;
    logic        keep;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        early_branch_valid;
    logic [31:0] early_branch_pc;
    logic        bht_update_valid;
    logic [31:0] bht_update_pc;
    logic        bht_update_taken;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PC_pype0;
    logic [31:0] PCp4_pype0;
    logic [31:0] Instraction_pype;
    logic        is_branch_predict_pype0;

    int n_checks = 0;
    int n_pass   = 0;
    int lat      = 0;
    int resp_cnt = 0;

    fetch_stage dut (
        .clk                     (clk),
        .rst                     (rst),
        .keep                    (keep),
        .redirect_valid          (redirect_valid),
        .redirect_pc             (redirect_pc),
        .early_branch_valid      (early_branch_valid),
        .early_branch_pc         (early_branch_pc),
        .bht_update_valid        (bht_update_valid),
        .bht_update_pc           (bht_update_pc),
        .bht_update_taken        (bht_update_taken),
        .imem_req                (imem_req),
        .imem_addr               (imem_addr),
        .imem_ready              (imem_ready),
        .imem_rdata              (imem_rdata),
        .PC_pype0                (PC_pype0),
        .PCp4_pype0              (PCp4_pype0),
        .Instraction_pype        (Instraction_pype),
        .is_branch_predict_pype0 (is_branch_predict_pype0)
    );

    // instruction memory image
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h04:         return 32'h0010_0113;
            32'h20:         return 32'h0100_006F;   // jal x0,+16
            32'h40, 32'h80: return 32'h0200_0063;   // beq x0,x0,+32
            default:        return {a[11:0], 20'h00093};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory responder: answers after `lat` waiting cycles, 2ns past the edge
    initial begin
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (!imem_req) begin
                imem_ready = 1'b0;
                resp_cnt   = 0;
            end else if (resp_cnt >= lat) begin
                imem_ready = 1'b1;
                imem_rdata = mem_word(imem_addr);
                resp_cnt   = 0;
            end else begin
                imem_ready = 1'b0;
                resp_cnt++;
            end
        end
    end

    initial begin
        rst = 1'b1; keep = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        early_branch_valid = 1'b0; early_branch_pc = 32'h0;
        bht_update_valid = 1'b0; bht_update_pc = 32'h0; bht_update_taken = 1'b0;
        #1 rst = 1'b0;
        repeat (2) tick();
        chk("rst_pc",   PC_pype0, 32'h0);
        chk("rst_pcp4", PCp4_pype0, 32'h0);
        chk("rst_inst", Instraction_pype, NOP);
        chk("rst_pred", 32'(is_branch_predict_pype0), 32'h0);
        chk("rst_req",  32'(imem_req), 32'h0);
        rst = 1'b1;
        bht_update_valid = 1'b1; bht_update_pc = 32'h40; bht_update_taken = 1'b1;

        tick();
        chk("first_req",  32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        chk("not_yet",    Instraction_pype, NOP);
        tick();
        bht_update_valid = 1'b0;
        chk("w0_pc",   PC_pype0, 32'h0);
        chk("w0_pcp4", PCp4_pype0, 32'h4);
        chk("w0_inst", Instraction_pype, 32'h0000_0093);
        tick();
        chk("w1_pc",   PC_pype0, 32'h4);
        chk("w1_pcp4", PCp4_pype0, 32'h8);
        chk("w1_inst", Instraction_pype, 32'h0010_0113);
        keep = 1'b1;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_pc",   PC_pype0, 32'h4);
            chk("hold_inst", Instraction_pype, 32'h0010_0113);
            chk("hold_req",  32'(imem_req), 32'h0);
        end
        keep = 1'b0;
        tick();
        chk("rel_pc",   PC_pype0, 32'h8);
        chk("rel_inst", Instraction_pype, 32'h0080_0093);
        lat = 2;
        tick();
        chk("seq_pc",    PC_pype0, 32'hC);
        chk("pend_addr", imem_addr, 32'h10);
        redirect_valid = 1'b1; redirect_pc = 32'h100;

        tick();
        redirect_valid = 1'b0;
        chk("bub_pc",    PC_pype0, 32'h0);
        chk("bub_inst",  Instraction_pype, NOP);
        chk("drop_addr", imem_addr, 32'h10);
        chk("drop_req",  32'(imem_req), 32'h1);
        tick();
        lat = 0;
        chk("drop_inst", Instraction_pype, NOP);
        tick();
        chk("redir_addr", imem_addr, 32'h100);
        chk("stale_inst", Instraction_pype, NOP);
        tick();
        chk("tgt_pc",   PC_pype0, 32'h100);
        chk("tgt_inst", Instraction_pype, 32'h1000_0093);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        early_branch_valid = 1'b1; early_branch_pc = 32'h300;

        tick();
        redirect_valid = 1'b0; early_branch_valid = 1'b0;
        chk("prio_addr", imem_addr, 32'h200);
        chk("prio_bub",  Instraction_pype, NOP);
        tick();
        chk("prio_pc", PC_pype0, 32'h200);
        early_branch_valid = 1'b1; early_branch_pc = 32'h20;
        tick();
        early_branch_valid = 1'b0;
        chk("early_addr", imem_addr, 32'h20);
        tick();
        chk("jal_pc",   PC_pype0, 32'h20);
        chk("jal_inst", Instraction_pype, 32'h0100_006F);
        chk("jal_pred", 32'(is_branch_predict_pype0), EXP_JAL_PRED);
        chk("jal_next", imem_addr, EXP_JAL_NEXT);
        redirect_valid = 1'b1; redirect_pc = 32'h40;

        tick();
        redirect_valid = 1'b0;
        chk("beq_addr", imem_addr, 32'h40);
        tick();
        chk("beq_pc",   PC_pype0, 32'h40);
        chk("beq_pred", 32'(is_branch_predict_pype0), EXP_BEQ_PRED);
        chk("beq_next", imem_addr, EXP_BEQ_NEXT);
        tick();
        chk("beq_after_pc", PC_pype0, EXP_BEQ_NEXT);
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        chk("nt_addr", imem_addr, 32'h80);
        tick();
        chk("nt_pc",   PC_pype0, 32'h80);
        chk("nt_pred", 32'(is_branch_predict_pype0), 32'h0);
        chk("nt_next", imem_addr, 32'h84);
        lat = 3;

        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_req",  32'(imem_req), 32'h0);
        chk("mid_rst_pc",   PC_pype0, 32'h0);
        chk("mid_rst_inst", Instraction_pype, NOP);
        tick();
        rst = 1'b1; lat = 0;
        tick();
        chk("restart_req",  32'(imem_req), 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        tick();
        chk("restart_pc",   PC_pype0, 32'h0);
        chk("restart_inst", Instraction_pype, 32'h0000_0093);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
